pwm_note_core: RTL and testbench
================================

Name: pwm_note_core

Overview:
Single-clock audio helper combining a 10-bit PWM serializer and a 5-bit note-index counter. The PWM half turns a duty-cycle word into a fixed-period pulse train for the audio jack. The counter half steps through a 32-entry note table on an enable strobe. It sits between the tone/duty logic of the audio controller and the audioOut pin.

Parameters:
PWM_BITS, 10, width of duty word and PWM period counter (period = 2^PWM_BITS clocks)
CNT_BITS, 5, width of note-index counter (modulus 2^CNT_BITS = 32)

Ports:
clk  input  1  system clock (100 MHz); all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
duty_cycle  input  PWM_BITS  requested PWM high time in clocks per period
signal  output  1  PWM output to audio jack
period_start  output  1  high while PWM counter == 0
cnt_en  input  1  counter enable
cnt_step  input  1  single-cycle advance strobe (qualified by cnt_en)
cnt_clr  input  1  synchronous clear of counter
cnt_out  output  CNT_BITS  current note index
cnt_max  output  1  high while cnt_out == 2^CNT_BITS-1

Behaviour:
Reset (reset==0, asynchronous, any time):
- pwm_cnt=0, duty_q=0, cnt_out=0; hence signal=0, period_start=1, cnt_max=0.
- Mid-operation reset aborts the current period immediately; no partial state survives.
PWM serializer:
- pwm_cnt: PWM_BITS free-running up-counter, +1 every clock, wraps 1023->0 with no idle cycle; period exactly 1024 clocks.
- duty_q: internal duty latch. Loaded from duty_cycle only on the edge where pwm_cnt==1023, so the new value governs the period starting at pwm_cnt==0. Changes of duty_cycle at any other time have no effect on the current period (glitch-free).
- signal = (pwm_cnt < duty_q), combinational from registers only (no path from duty_cycle to signal).
- duty_q==0 -> signal constantly 0. duty_q==1023 -> high 1023 of 1024 clocks (low only at pwm_cnt==1023). 100% duty is not representable.
- Unsigned compare; no other arithmetic.
- period_start = (pwm_cnt==0).
- First period after reset always outputs 0 (duty_q=0). A duty applied before reset release takes effect from the second period (clocks 1024..2047).
Note counter:
- Priority per clock edge: cnt_clr > (cnt_en && cnt_step) > hold.
- cnt_clr==1: cnt_out<=0, regardless of en/step.
- cnt_en && cnt_step: cnt_out<=cnt_out+1 mod 32 (31->0 wrap, no saturation).
- Otherwise hold. cnt_step without cnt_en is ignored.
- cnt_max = (cnt_out==31), combinational from register.
- Counter and PWM are fully independent; counter activity never disturbs pwm_cnt or duty_q.
Latency:
- Counter update is visible one clock after the strobe edge.
- Duty change is visible at the next period boundary, i.e. 1 to 1024 clocks later.

Test Plan:
- Reset low 3 clocks, duty_cycle=512, release: signal=0 for clocks 0..1023; period_start pulses at clocks 0 and 1024; next period signal high for pwm_cnt 0..511 (512 clocks), low for 512..1023.
- duty_cycle=0 then 1023 across periods: 0 -> signal never high in that period; 1023 -> exactly 1023 high clocks, low only at pwm_cnt==1023.
- Change duty_cycle 512->100 when pwm_cnt==300: current period stays high through pwm_cnt 511; next period high for exactly 100 clocks.
- cnt_en=1 with 33 cnt_step pulses from reset: cnt_out goes 0..31, cnt_max high only at 31, then wraps to 0 and reaches 1 on pulse 33. cnt_step with cnt_en=0 leaves cnt_out unchanged.
- cnt_out=17, assert cnt_clr together with cnt_en=1, cnt_step=1: cnt_out=0 next clock (clear wins); PWM waveform unaffected.
- Assert reset asynchronously mid-period (pwm_cnt=700, cnt_out=9, duty 800): signal, cnt_out and pwm_cnt go to 0 before the next clock edge; after release, first period signal=0.

Source files
------------

// File: rtl/pwm_note_core.sv
// Audio helper: fixed-period PWM serializer for the audio jack plus an
// independent modulo-2^CNT_BITS note-index counter advanced by a qualified strobe.
module pwm_note_core #(
    parameter int unsigned PWM_BITS = 10,
    parameter int unsigned CNT_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty_cycle,
    output logic                signal,
    output logic                period_start,
    input  logic                cnt_en,
    input  logic                cnt_step,
    input  logic                cnt_clr,
    output logic [CNT_BITS-1:0] cnt_out,
    output logic                cnt_max
);

    localparam logic [PWM_BITS-1:0] PWM_ONE = 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = 1;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q,    duty_d;
    logic [CNT_BITS-1:0] cnt_q,     cnt_d;
    logic                period_end;

    // Duty is captured only on the last clock of a period so a mid-period
    // change of duty_cycle can never glitch the waveform being emitted.
    always_comb begin
        period_end = (pwm_cnt_q == '1);
        pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
        duty_d     = duty_q;
        if (period_end) begin
            duty_d = duty_cycle;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en && cnt_step) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            cnt_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
        end
    end

    assign signal       = (pwm_cnt_q < duty_q);
    assign period_start = (pwm_cnt_q == '0);
    assign cnt_out      = cnt_q;
    assign cnt_max      = (cnt_q == '1);

endmodule

// File: tb/tb_pwm_note_core.sv
// Self-checking bench for pwm_note_core: directed scenarios plus random
// stimulus, compared each cycle against a period/phase reference model.
module tb_pwm_note_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] duty_cycle;
    logic       signal;
    logic       period_start;
    logic       cnt_en;
    logic       cnt_step;
    logic       cnt_clr;
    logic [4:0] cnt_out;
    logic       cnt_max;

    pwm_note_core #(.PWM_BITS(10), .CNT_BITS(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .duty_cycle  (duty_cycle),
        .signal      (signal),
        .period_start(period_start),
        .cnt_en      (cnt_en),
        .cnt_step    (cnt_step),
        .cnt_clr     (cnt_clr),
        .cnt_out     (cnt_out),
        .cnt_max     (cnt_max)
    );

    always #5 clk = ~clk;

    // Reference model: phase within the 1024-clock period, latched duty, note index.
    int unsigned ph;
    int unsigned dm;
    int unsigned note;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph   = 0;
        dm   = 0;
        note = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".signal"}, {31'd0, signal}, (ph < dm) ? 32'd1 : 32'd0);
        check({tag, ".pstart"}, {31'd0, period_start}, (ph == 0) ? 32'd1 : 32'd0);
        check({tag, ".cnt"}, {27'd0, cnt_out}, note);
        check({tag, ".cmax"}, {31'd0, cnt_max}, (note == 31) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (ph == 1023) dm = duty_cycle;
            ph = (ph + 1) % 1024;
            if (cnt_clr) note = 0;
            else if (cnt_en && cnt_step) note = (note + 1) % 32;
        end
        @(negedge clk);
        check_outputs("cyc");
    endtask

    // Runs 1024 clocks from the current phase, optionally changing duty
    // mid-way, and checks how many clocks the DUT drove signal high.
    task automatic run_period(input string tag, input int unsigned exp_hi,
                              input int chg_at, input logic [9:0] chg_val);
        int unsigned hi;
        hi = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i == chg_at) duty_cycle = chg_val;
            if (signal) hi++;
            step();
        end
        check(tag, hi, exp_hi);
    endtask

    initial begin
        int unsigned guard;
        reset      = 1'b0;
        duty_cycle = 10'd512;
        cnt_en     = 1'b0;
        cnt_step   = 1'b0;
        cnt_clr    = 1'b0;
        model_reset();

        @(negedge clk);
        check("rst.signal", {31'd0, signal}, 32'd0);
        check("rst.pstart", {31'd0, period_start}, 32'd1);
        check("rst.cnt", {27'd0, cnt_out}, 32'd0);
        check("rst.cmax", {31'd0, cnt_max}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;

        run_period("p1_hi", 0, -1, 10'd0);
        run_period("p2_hi", 512, -1, 10'd0);
        duty_cycle = 10'd0;
        run_period("p3_hi", 512, -1, 10'd0);
        duty_cycle = 10'd1023;
        run_period("p4_hi", 0, -1, 10'd0);
        duty_cycle = 10'd512;
        run_period("p5_hi", 1023, -1, 10'd0);
        run_period("p6_hi", 512, 300, 10'd100);
        run_period("p7_hi", 100, -1, 10'd0);

        cnt_en = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            cnt_step = 1'b1;
            step();
            cnt_step = 1'b0;
            check("cnt_pulse", {27'd0, cnt_out}, k % 32);
            check("cnt_max_pulse", {31'd0, cnt_max}, ((k % 32) == 31) ? 32'd1 : 32'd0);
            step();
        end
        cnt_en   = 1'b0;
        cnt_step = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("cnt_no_en", {27'd0, cnt_out}, 32'd1);

        cnt_en = 1'b1;
        for (int i = 0; i < 16; i++) step();
        check("cnt_17", {27'd0, cnt_out}, 32'd17);
        cnt_clr = 1'b1;
        step();
        check("cnt_clr_wins", {27'd0, cnt_out}, 32'd0);
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_step = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) duty_cycle = 10'($urandom);
            cnt_en   = 1'($urandom);
            cnt_step = 1'($urandom);
            cnt_clr  = ($urandom_range(15) == 0);
            step();
        end

        duty_cycle = 10'd800;
        cnt_en = 1'b0;
        cnt_step = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        cnt_en = 1'b1;
        cnt_step = 1'b1;
        for (int i = 0; i < 9; i++) step();
        cnt_en = 1'b0;
        cnt_step = 1'b0;
        guard = 0;
        while (!(dm == 800 && ph == 700) && guard < 2100) begin
            step();
            guard++;
        end
        check("ar_setup_timeout", (guard < 2100) ? 32'd1 : 32'd0, 32'd1);
        check("ar_pre_cnt", {27'd0, cnt_out}, 32'd9);
        check("ar_pre_signal", {31'd0, signal}, 32'd1);

        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("ar_signal", {31'd0, signal}, 32'd0);
        check("ar_pstart", {31'd0, period_start}, 32'd1);
        check("ar_cnt", {27'd0, cnt_out}, 32'd0);
        check("ar_cmax", {31'd0, cnt_max}, 32'd0);
        @(negedge clk);
        step();
        step();
        reset = 1'b1;
        run_period("post_rst_hi", 0, -1, 10'd0);
        run_period("post_rst2_hi", 800, -1, 10'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
